d_stage_ctrl: RTL and testbench

Decode-stage controller that consumes the F/D pipeline register contents (`D_PC`, `D_Ins`) and produces the fetch-side controls `NPC`, `F_Stall`, `D_Stall` and `D_Flush`. It owns the D/E pipeline register and a two-entry hazard scoreboard covering E and M. It also owns a multiply/divide busy counter. Branches and jumps resolve in D with no delay slot; a taken control transfer squashes the instruction currently in F.

---
 rtl/d_stage_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_d_stage_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_stage_ctrl.sv
// Decode-stage controller: hazard scoreboard (E/M), HI/LO busy
// counter, D/E register, and next-PC / stall / flush generation.
module d_stage_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_PC,
  input  logic [31:0] D_PC,
  input  logic [31:0] D_Ins,
  input  logic [31:0] D_RS_Data,
  input  logic [31:0] D_RT_Data,
  output logic [31:0] NPC,
  output logic        F_Stall,
  output logic        D_Stall,
  output logic        D_Flush,
  output logic [31:0] E_PC,
  output logic [31:0] E_Ins,
  output logic [4:0]  E_A3,
  output logic [1:0]  E_Tnew,
  output logic [4:0]  M_A3,
  output logic [1:0]  M_Tnew
);

  localparam logic [3:0] LP_MULT = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV  = 4'(DIV_CYCLES);

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic        w_spc;
  logic        w_ralu;
  logic        w_jr;
  logic        w_mult;
  logic        w_div;
  logic        w_mfhi;
  logic        w_mflo;
  logic        w_addiu;
  logic        w_ori;
  logic        w_lui;
  logic        w_lw;
  logic        w_sw;
  logic        w_beq;
  logic        w_bne;
  logic        w_j;
  logic        w_jal;
  logic        w_md;
  logic        w_hilo;
  logic        w_rs_use;
  logic        w_rt_use;
  logic [1:0]  w_rs_tuse;
  logic [1:0]  w_rt_tuse;
  logic [4:0]  w_a3;
  logic [1:0]  w_tnew;
  logic        w_haz_rs;
  logic        w_haz_rt;
  logic        w_md_stall;
  logic        w_stall;
  logic        w_eq;
  logic        w_taken;
  logic [31:0] w_pc4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_tgt;
  logic [3:0]  r_busy;

  assign w_op = D_Ins[31:26];
  assign w_fn = D_Ins[5:0];
  assign w_rs = D_Ins[25:21];
  assign w_rt = D_Ins[20:16];
  assign w_rd = D_Ins[15:11];

  assign w_spc   = (w_op == 6'h00);
  assign w_ralu  = w_spc & ((w_fn == 6'h20) | (w_fn == 6'h22) |
                            (w_fn == 6'h24) | (w_fn == 6'h25) |
                            (w_fn == 6'h2a));
  assign w_jr    = w_spc & (w_fn == 6'h08);
  assign w_mult  = w_spc & (w_fn == 6'h18);
  assign w_div   = w_spc & (w_fn == 6'h1a);
  assign w_mfhi  = w_spc & (w_fn == 6'h10);
  assign w_mflo  = w_spc & (w_fn == 6'h12);
  assign w_addiu = (w_op == 6'h09);
  assign w_ori   = (w_op == 6'h0d);
  assign w_lui   = (w_op == 6'h0f);
  assign w_lw    = (w_op == 6'h23);
  assign w_sw    = (w_op == 6'h2b);
  assign w_beq   = (w_op == 6'h04);
  assign w_bne   = (w_op == 6'h05);
  assign w_j     = (w_op == 6'h02);
  assign w_jal   = (w_op == 6'h03);

  assign w_md   = w_mult | w_div;
  assign w_hilo = w_md | w_mfhi | w_mflo;

  // Source usage and the cycle each source is first needed
  assign w_rs_use  = w_beq | w_bne | w_jr | w_ralu | w_addiu |
                     w_ori | w_lw | w_sw | w_md;
  assign w_rt_use  = w_beq | w_bne | w_ralu | w_md | w_sw;
  assign w_rs_tuse = (w_beq | w_bne | w_jr) ? 2'd0 : 2'd1;
  assign w_rt_tuse = (w_beq | w_bne) ? 2'd0 :
                     w_sw ? 2'd2 : 2'd1;

  // Destination register and result latency on entry to E
  always_comb begin
    w_a3   = 5'd0;
    w_tnew = 2'd0;
    unique case (1'b1)
      w_ralu, w_mfhi, w_mflo: begin
        w_a3   = w_rd;
        w_tnew = 2'd1;
      end
      w_addiu, w_ori, w_lui: begin
        w_a3   = w_rt;
        w_tnew = 2'd1;
      end
      w_lw: begin
        w_a3   = w_rt;
        w_tnew = 2'd2;
      end
      w_jal: begin
        w_a3   = 5'd31;
        w_tnew = 2'd0;
      end
      default: begin
        w_a3   = 5'd0;
        w_tnew = 2'd0;
      end
    endcase
  end

  // Data hazard: producer in E or M not ready by the source's Tuse
  always_comb begin
    w_haz_rs = 1'b0;
    w_haz_rt = 1'b0;
    if (w_rs_use && (w_rs != 5'd0)) begin
      w_haz_rs = ((w_rs == E_A3) && (E_Tnew > w_rs_tuse)) ||
                 ((w_rs == M_A3) && (M_Tnew > w_rs_tuse));
    end
    if (w_rt_use && (w_rt != 5'd0)) begin
      w_haz_rt = ((w_rt == E_A3) && (E_Tnew > w_rt_tuse)) ||
                 ((w_rt == M_A3) && (M_Tnew > w_rt_tuse));
    end
  end

  assign w_md_stall = w_hilo & (r_busy != 4'd0);
  assign w_stall    = w_haz_rs | w_haz_rt | w_md_stall;
  assign F_Stall    = w_stall;
  assign D_Stall    = w_stall;

  assign w_eq     = (D_RS_Data == D_RT_Data);
  assign w_taken  = (w_beq & w_eq) | (w_bne & ~w_eq) |
                    w_j | w_jal | w_jr;
  assign w_pc4    = D_PC + 32'd4;
  assign w_br_tgt = w_pc4 +
                    {{14{D_Ins[15]}}, D_Ins[15:0], 2'b00};

  // Redirect target for whichever transfer D holds
  always_comb begin
    w_tgt = w_br_tgt;
    unique case (1'b1)
      w_j, w_jal: w_tgt = {D_PC[31:28], D_Ins[25:0], 2'b00};
      w_jr:       w_tgt = D_RS_Data;
      default:    w_tgt = w_br_tgt;
    endcase
  end

  assign D_Flush = w_taken & ~w_stall;
  assign NPC     = D_Flush ? w_tgt : (F_PC + 32'd4);

  // D/E register and E->M scoreboard shift; bubble on stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      E_PC   <= 32'd0;
      E_Ins  <= 32'd0;
      E_A3   <= 5'd0;
      E_Tnew <= 2'd0;
      M_A3   <= 5'd0;
      M_Tnew <= 2'd0;
    end else begin
      M_A3   <= E_A3;
      M_Tnew <= (E_Tnew != 2'd0) ? (E_Tnew - 2'd1) : 2'd0;
      if (w_stall) begin
        E_PC   <= 32'd0;
        E_Ins  <= 32'd0;
        E_A3   <= 5'd0;
        E_Tnew <= 2'd0;
      end else begin
        E_PC   <= D_PC;
        E_Ins  <= D_Ins;
        E_A3   <= w_a3;
        E_Tnew <= w_tnew;
      end
    end
  end

  // HI/LO busy counter: load when mult/div issues, else count down
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 4'd0;
    end else if (w_md && !w_stall) begin
      r_busy <= w_mult ? LP_MULT : LP_DIV;
    end else if (r_busy != 4'd0) begin
      r_busy <= r_busy - 4'd1;
    end
  end

endmodule

// File: tb/tb_d_stage_ctrl.sv
// Bench for d_stage_ctrl: decode vector table under reset,
// directed hazard sequences, and random stream vs a reference model.
module tb_d_stage_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_Ins;
  logic [31:0] D_RS_Data;
  logic [31:0] D_RT_Data;
  logic [31:0] NPC;
  logic        F_Stall;
  logic        D_Stall;
  logic        D_Flush;
  logic [31:0] E_PC;
  logic [31:0] E_Ins;
  logic [4:0]  E_A3;
  logic [1:0]  E_Tnew;
  logic [4:0]  M_A3;
  logic [1:0]  M_Tnew;

  int n_chk = 0;
  int n_err = 0;

  d_stage_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .F_PC(F_PC), .D_PC(D_PC),
    .D_Ins(D_Ins), .D_RS_Data(D_RS_Data), .D_RT_Data(D_RT_Data),
    .NPC(NPC), .F_Stall(F_Stall), .D_Stall(D_Stall),
    .D_Flush(D_Flush), .E_PC(E_PC), .E_Ins(E_Ins), .E_A3(E_A3),
    .E_Tnew(E_Tnew), .M_A3(M_A3), .M_Tnew(M_Tnew)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int tu_rs;
    int tu_rt;
    int a3;
    int tnew;
    int busy_load;
    bit hilo;
    int kind;
  } dec_t;

  int          m_e_a3, m_e_tnew, m_m_a3, m_m_tnew, m_busy;
  logic [31:0] m_e_pc, m_e_ins;

  function automatic dec_t mdec(logic [31:0] ins);
    dec_t d;
    int op, fn, rt, rd;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    rt = int'(ins[20:16]);
    rd = int'(ins[15:11]);
    d = '{tu_rs: -1, tu_rt: -1, a3: 0, tnew: 0,
          busy_load: 0, hilo: 0, kind: 0};
    if (op == 0) begin
      case (fn)
        'h20, 'h22, 'h24, 'h25, 'h2a: begin
          d.tu_rs = 1; d.tu_rt = 1; d.a3 = rd; d.tnew = 1;
        end
        'h08: begin d.tu_rs = 0; d.kind = 4; end
        'h18, 'h1a: begin
          d.tu_rs = 1; d.tu_rt = 1; d.hilo = 1;
          d.busy_load = (fn == 'h18) ? MC : DC;
        end
        'h10, 'h12: begin d.a3 = rd; d.tnew = 1; d.hilo = 1; end
        default: ;
      endcase
    end else begin
      case (op)
        'h09, 'h0d: begin d.tu_rs = 1; d.a3 = rt; d.tnew = 1; end
        'h0f: begin d.a3 = rt; d.tnew = 1; end
        'h23: begin d.tu_rs = 1; d.a3 = rt; d.tnew = 2; end
        'h2b: begin d.tu_rs = 1; d.tu_rt = 2; end
        'h04: begin d.tu_rs = 0; d.tu_rt = 0; d.kind = 1; end
        'h05: begin d.tu_rs = 0; d.tu_rt = 0; d.kind = 2; end
        'h02: d.kind = 3;
        'h03: begin d.kind = 3; d.a3 = 31; end
        default: ;
      endcase
    end
    return d;
  endfunction

  function automatic bit src_haz(int r, int tu);
    if (tu < 0 || r == 0) return 0;
    return (r == m_e_a3 && m_e_tnew > tu) ||
           (r == m_m_a3 && m_m_tnew > tu);
  endfunction

  function automatic bit m_stall();
    dec_t d;
    d = mdec(D_Ins);
    return src_haz(int'(D_Ins[25:21]), d.tu_rs) ||
           src_haz(int'(D_Ins[20:16]), d.tu_rt) ||
           (d.hilo && m_busy > 0);
  endfunction

  function automatic bit m_taken();
    dec_t d;
    d = mdec(D_Ins);
    case (d.kind)
      1: return D_RS_Data == D_RT_Data;
      2: return D_RS_Data != D_RT_Data;
      3, 4: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_npc();
    dec_t d;
    logic [31:0] off;
    d = mdec(D_Ins);
    if (m_stall() || !m_taken()) return F_PC + 4;
    off = {{16{D_Ins[15]}}, D_Ins[15:0]};
    case (d.kind)
      3: return (D_PC & 32'hF000_0000) | (32'(D_Ins[25:0]) * 4);
      4: return D_RS_Data;
      default: return D_PC + 4 + off * 4;
    endcase
  endfunction

  task automatic m_clear();
    m_e_a3 = 0; m_e_tnew = 0; m_m_a3 = 0; m_m_tnew = 0;
    m_busy = 0; m_e_pc = 0; m_e_ins = 0;
  endtask

  task automatic m_edge();
    dec_t d;
    bit st;
    if (reset) begin
      m_clear();
      return;
    end
    d  = mdec(D_Ins);
    st = m_stall();
    if (!st && d.busy_load > 0) m_busy = d.busy_load;
    else if (m_busy > 0) m_busy = m_busy - 1;
    m_m_a3   = m_e_a3;
    m_m_tnew = (m_e_tnew > 0) ? m_e_tnew - 1 : 0;
    if (st) begin
      m_e_a3 = 0; m_e_tnew = 0; m_e_pc = 0; m_e_ins = 0;
    end else begin
      m_e_a3 = d.a3; m_e_tnew = d.tnew;
      m_e_pc = D_PC; m_e_ins = D_Ins;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic cmp_all(string tag);
    bit st;
    st = m_stall();
    chk({tag, ".NPC"}, NPC, m_npc());
    chk({tag, ".F_Stall"}, 32'(F_Stall), 32'(st));
    chk({tag, ".D_Stall"}, 32'(D_Stall), 32'(st));
    chk({tag, ".D_Flush"}, 32'(D_Flush), 32'(m_taken() && !st));
    chk({tag, ".E_PC"}, E_PC, m_e_pc);
    chk({tag, ".E_Ins"}, E_Ins, m_e_ins);
    chk({tag, ".E_A3"}, 32'(E_A3), 32'(m_e_a3));
    chk({tag, ".E_Tnew"}, 32'(E_Tnew), 32'(m_e_tnew));
    chk({tag, ".M_A3"}, 32'(M_A3), 32'(m_m_a3));
    chk({tag, ".M_Tnew"}, 32'(M_Tnew), 32'(m_m_tnew));
  endtask

  task automatic sample(string tag);
    #3;
    cmp_all(tag);
  endtask

  task automatic edge_();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic drive(logic [31:0] ins);
    D_Ins = ins;
    D_PC  = 32'h0000_4000;
    F_PC  = 32'h0000_4004;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      drive(32'h0);
      sample("drain");
      edge_();
    end
  endtask

  function automatic logic [31:0] gen_ins();
    logic [4:0]  rs, rt, rd;
    logic [15:0] im;
    int k;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    im = ($urandom_range(0, 3) == 0) ? 16'($urandom) :
         16'($urandom_range(0, 7));
    k  = int'($urandom_range(0, 19));
    case (k)
      0:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      1:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      2:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      3:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      4:  return {6'h00, rs, rt, rd, 5'd0, 6'h2a};
      5:  return {6'h00, rs, 15'd0, 6'h08};
      6:  return {6'h00, rs, rt, 10'd0, 6'h18};
      7:  return {6'h00, rs, rt, 10'd0, 6'h1a};
      8:  return {16'd0, rd, 5'd0, 6'h10};
      9:  return {16'd0, rd, 5'd0, 6'h12};
      10: return {6'h09, rs, rt, im};
      11: return {6'h0d, rs, rt, im};
      12: return {6'h0f, 5'd0, rt, im};
      13: return {6'h23, rs, rt, im};
      14: return {6'h2b, rs, rt, im};
      15: return {6'h04, rs, rt, im};
      16: return {6'h05, rs, rt, im};
      17: return {6'h02, 26'($urandom)};
      18: return {6'h03, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [31:0] ins, dpc, fpc, rs, rt, npc;
    logic        flush;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{32'h11090003, 32'h00003000, 32'h00003004,
                    32'd5, 32'd5, 32'h00003010, 1'b1});
    tbl.push_back('{32'h11090003, 32'h00003000, 32'h00003004,
                    32'd5, 32'd6, 32'h00003008, 1'b0});
    tbl.push_back('{32'h15090003, 32'h00003000, 32'h00003004,
                    32'd5, 32'd6, 32'h00003010, 1'b1});
    tbl.push_back('{32'h15090003, 32'h00003000, 32'h00003004,
                    32'd7, 32'd7, 32'h00003008, 1'b0});
    tbl.push_back('{32'h0C000C10, 32'h00003004, 32'h00003008,
                    32'd0, 32'd0, 32'h00003040, 1'b1});
    tbl.push_back('{32'h08000001, 32'h90000000, 32'h90000004,
                    32'd0, 32'd0, 32'h90000004, 1'b1});
    tbl.push_back('{32'h03E00008, 32'h00003000, 32'h00003004,
                    32'h00001234, 32'd0, 32'h00001234, 1'b1});
    tbl.push_back('{32'h1109FFFF, 32'h00003000, 32'h00003004,
                    32'd1, 32'd1, 32'h00003000, 1'b1});
    tbl.push_back('{32'h11090001, 32'hFFFFFFF8, 32'hFFFFFFFC,
                    32'd2, 32'd2, 32'h00000000, 1'b1});
    tbl.push_back('{32'h01084820, 32'h00003000, 32'hFFFFFFFC,
                    32'd0, 32'd0, 32'h00000000, 1'b0});
    tbl.push_back('{32'h00000000, 32'h00003000, 32'h00005000,
                    32'd0, 32'd0, 32'h00005004, 1'b0});
    tbl.push_back('{32'hFC000000, 32'h00003000, 32'h00005000,
                    32'd0, 32'd0, 32'h00005004, 1'b0});
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    D_RS_Data = 0;
    D_RT_Data = 0;
    drive(32'h0);
    m_clear();
    #2;
    chk("rst.E_PC", E_PC, 32'h0);
    chk("rst.E_Ins", E_Ins, 32'h0);
    chk("rst.E_A3", 32'(E_A3), 32'h0);
    chk("rst.M_Tnew", 32'(M_Tnew), 32'h0);

    foreach (tbl[i]) begin
      D_Ins = tbl[i].ins; D_PC = tbl[i].dpc; F_PC = tbl[i].fpc;
      D_RS_Data = tbl[i].rs; D_RT_Data = tbl[i].rt;
      #1;
      chk($sformatf("tbl%0d.NPC", i), NPC, tbl[i].npc);
      chk($sformatf("tbl%0d.flush", i), 32'(D_Flush),
          32'(tbl[i].flush));
      chk($sformatf("tbl%0d.stall", i), 32'(D_Stall), 32'h0);
    end

    @(posedge clk);
    #1;
    reset = 1'b0;
    D_RS_Data = 0;
    D_RT_Data = 0;

    // load-use: one bubble, then M holds lw
    drive(32'h8C080000); sample("lu0"); edge_();
    drive(32'h01084820); sample("lu1");
    chk("lu.stall1", 32'(D_Stall), 32'h1);
    edge_();
    chk("lu.bubble", E_Ins, 32'h0);
    sample("lu2");
    chk("lu.stall2", 32'(D_Stall), 32'h0);
    chk("lu.M_A3", 32'(M_A3), 32'd8);
    chk("lu.M_Tnew", 32'(M_Tnew), 32'd1);
    edge_();

    // jal writes $31 with Tnew 0
    D_Ins = 32'h0C000C10; D_PC = 32'h3004; F_PC = 32'h3008;
    sample("jal");
    chk("jal.NPC", NPC, 32'h00003040);
    chk("jal.flush", 32'(D_Flush), 32'h1);
    edge_();
    chk("jal.E_A3", 32'(E_A3), 32'd31);
    chk("jal.E_Tnew", 32'(E_Tnew), 32'd0);

    // mult then mflo: exactly MC stall cycles
    drain();
    drive(32'h01090018); sample("mul0");
    chk("mul.issue", 32'(D_Stall), 32'h0);
    edge_();
    drive(32'h00005012);
    for (int i = 0; i < MC; i++) begin
      sample("mul");
      chk($sformatf("mul.stall%0d", i), 32'(D_Stall), 32'h1);
      edge_();
    end
    sample("mul.end");
    chk("mul.release", 32'(D_Stall), 32'h0);
    edge_();
    chk("mflo.E_A3", 32'(E_A3), 32'd10);
    chk("mflo.E_Tnew", 32'(E_Tnew), 32'd1);

    // branch behind lw: two stall cycles
    drain();
    drive(32'h8C080000); sample("lb0"); edge_();
    D_RS_Data = 1; D_RT_Data = 1;
    drive(32'h11090003);
    for (int i = 0; i < 2; i++) begin
      sample("lb");
      chk($sformatf("lb.stall%0d", i), 32'(D_Stall), 32'h1);
      chk($sformatf("lb.noflush%0d", i), 32'(D_Flush), 32'h0);
      edge_();
    end
    sample("lb.go");
    chk("lb.flush", 32'(D_Flush), 32'h1);
    edge_();

    // branch behind ALU: one stall cycle
    drive(32'h01004020); sample("ab0"); edge_();
    drive(32'h11090003); sample("ab1");
    chk("ab.stall", 32'(D_Stall), 32'h1);
    edge_();
    sample("ab2");
    chk("ab.release", 32'(D_Stall), 32'h0);
    edge_();

    // $0 destination never stalls
    drive(32'h8C000000); sample("z0"); edge_();
    drive(32'h00004820); sample("z1");
    chk("zero.stall", 32'(D_Stall), 32'h0);
    edge_();

    // reset in the middle of a div stall
    drain();
    drive(32'h0109001A); sample("dv0"); edge_();
    drive(32'h00004010); sample("dv1");
    chk("div.stall", 32'(D_Stall), 32'h1);
    edge_();
    sample("dv2");
    #1;
    reset = 1'b1;
    #1;
    chk("rst2.E_PC", E_PC, 32'h0);
    chk("rst2.E_Ins", E_Ins, 32'h0);
    chk("rst2.E_A3", 32'(E_A3), 32'h0);
    chk("rst2.E_Tnew", 32'(E_Tnew), 32'h0);
    chk("rst2.M_A3", 32'(M_A3), 32'h0);
    chk("rst2.M_Tnew", 32'(M_Tnew), 32'h0);
    chk("rst2.stall", 32'(D_Stall), 32'h0);
    m_clear();
    edge_();
    reset = 1'b0;
    sample("post_rst");
    edge_();

    // random stream against the model
    for (int i = 0; i < 2000; i++) begin
      D_Ins = gen_ins();
      D_PC  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      F_PC  = D_PC + 4;
      D_RS_Data = 32'($urandom_range(0, 2));
      D_RT_Data = 32'($urandom_range(0, 2));
      sample("rnd");
      edge_();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_chk, n_err);
    $finish;
  end

endmodule
